// File: rtl/pipeline_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipeline_stage_elastic
//
// Purpose:
//   Multi-stage elastic pipeline register with valid/ready handshaking,
//   bubble collapsing and a synchronous flush. It sits between CPU pipeline
//   stages and absorbs downstream stalls without losing or duplicating words.
//   Words leave in strict FIFO order. With no stall, a word accepted in
//   cycle t is presented on out_* in cycle t+DEPTH.
//
// Parameters:
//   DATA_W    payload width in bits (>=1)
//   DEPTH     number of register stages (>=1), nominal latency in cycles
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (has priority over flush)
//   flush      in   synchronous kill of every in-flight entry
//   in_valid   in   upstream offers in_data
//   in_ready   out  block accepts in_data this cycle
//   in_data    in   upstream payload
//   out_valid  out  last stage holds a valid word
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  payload of the last stage (always visible)
//   occupancy  out  registered count of valid stages (PIPE_OCCUPANCY_EN only)
//
// Optional feature macro:
//   PIPE_OCCUPANCY_EN - adds the occupancy port and its counter.
// ---------------------------------------------------------------------------
module pipeline_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  // Per-stage state. Index DEPTH-1 is the tail that faces the output.
  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0][DATA_W-1:0] r_d;

  // Per-stage ready and per-stage source (what would move in on this edge).
  logic [DEPTH-1:0]             w_rdy;
  logic [DEPTH-1:0]             w_src_v;
  logic [DEPTH-1:0][DATA_W-1:0] w_src_d;

  // Ready chain from the tail backwards. An empty stage is always ready,
  // which lets bubbles collapse behind a stalled tail.
  always_comb begin
    w_rdy = '0;
    w_rdy[DEPTH-1] = out_ready | ~r_v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = w_rdy[i+1] | ~r_v[i];
    end
  end

  // Source of each stage: the input ports for stage 0, the previous stage otherwise.
  always_comb begin
    w_src_v    = '0;
    w_src_d    = '0;
    w_src_v[0] = in_valid;
    w_src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_v[i] = r_v[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

  // Stage registers: reset clears everything, flush kills valids but keeps data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_d <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_src_v[i];
          // Data is only overwritten by a real word, so an idle stage keeps
          // its last payload instead of picking up garbage.
          if (w_src_v[i]) begin
            r_d[i] <= w_src_d[i];
          end
        end
      end
    end
  end

  // Flush masks both handshakes in the same cycle so nothing crosses the
  // boundary while the pipe is being killed.
  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_v[DEPTH-1] & ~flush;
  assign out_data  = r_d[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] r_occ;
  logic             w_acc;
  logic             w_dlv;

  assign w_acc = in_valid & in_ready;
  assign w_dlv = out_valid & out_ready;

  // Occupancy counter tracks accepts minus deliveries; it equals popcount(r_v).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_acc && !w_dlv) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_acc && w_dlv) begin
      r_occ <= r_occ - OCC_W'(1);
    end else begin
      r_occ <= r_occ;
    end
  end

  assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stage_elastic
//
// Self-checking bench. A DEPTH=3 instance is driven from a table of
// per-cycle vectors (inputs plus expected outputs for that cycle); a DEPTH=1
// instance is exercised by a short hand-written sequence covering the
// simultaneous accept/deliver case and the occupancy counter.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_pipeline_stage_elastic;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        chk;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  logic clk;

  // DEPTH=3 instance
  logic        rst3, flush3, iv3, ir3, ov3, or3;
  logic [31:0] din3, dout3;
  logic [1:0]  occ3;

  // DEPTH=1 instance
  logic        rst1, flush1, iv1, ir1, ov1, or1;
  logic [31:0] din1, dout1;
  logic [0:0]  occ1;

  int n_checks;
  int n_errors;
  vec_t vecs[$];

  pipeline_stage_elastic #(.DATA_W(32), .DEPTH(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .flush     (flush3),
    .in_valid  (iv3),
    .in_ready  (ir3),
    .in_data   (din3),
    .out_valid (ov3),
    .out_ready (or3),
    .out_data  (dout3)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ3)
`endif
  );

  pipeline_stage_elastic #(.DATA_W(32), .DEPTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .flush     (flush1),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .in_data   (din1),
    .out_valid (ov1),
    .out_ready (or1),
    .out_data  (dout1)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                              input logic [31:0] din, input logic ordy, input logic chk,
                              input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                              input int e_occ);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.din = din; v.ordy = ordy;
    v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One cycle on the DEPTH=1 instance: drive, settle, compare.
  task automatic step1(input string nm, input logic rst, input logic flush, input logic iv,
                       input logic [31:0] din, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                       input int e_occ);
    @(negedge clk);
    rst1 = rst; flush1 = flush; iv1 = iv; din1 = din; or1 = ordy;
    #1;
    check({nm, " in_ready"},  {31'd0, ir1}, {31'd0, e_ir});
    check({nm, " out_valid"}, {31'd0, ov1}, {31'd0, e_ov});
    check({nm, " out_data"},  dout1, e_od);
`ifdef PIPE_OCCUPANCY_EN
    check({nm, " occupancy"}, {31'd0, occ1}, 32'(e_occ));
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst3 = 1'b1; flush3 = 1'b0; iv3 = 1'b0; din3 = 32'h0; or3 = 1'b0;
    rst1 = 1'b1; flush1 = 1'b0; iv1 = 1'b0; din1 = 32'h0; or1 = 1'b0;

    //               rst   flush iv    din       ordy  chk   e_ir  e_ov  e_od      occ
    // reset (2 cycles)
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  0)); // 0
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  0)); // 1
    // stream 1..4, out_ready high
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  0)); // 2
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1)); // 3
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  2)); // 4
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 1'b1, 32'h1,  3)); // 5
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h2,  3)); // 6
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h3,  2)); // 7
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1)); // 8
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h4,  0)); // 9
    // backpressure A..D
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 1'b0, 32'h4,  0)); // 10
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 1'b1, 1'b0, 32'h4,  1)); // 11
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 1'b1, 1'b0, 32'h4,  2)); // 12
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hD,  1'b0, 1'b1, 1'b0, 1'b1, 32'hA,  3)); // 13
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hD,  1'b1, 1'b1, 1'b1, 1'b1, 32'hA,  3)); // 14
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'hB,  3)); // 15
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  2)); // 16
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'hD,  1)); // 17
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'hD,  0)); // 18
    // bubble collapse: 0x11, idle, 0x22, out_ready low
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD,  0)); // 19
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'hD,  1)); // 20
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD,  1)); // 21
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 2)); // 22
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 2)); // 23
    // third word in, then flush with input offered
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 2)); // 24
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 3)); // 25
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 0)); // 26
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 0)); // 27
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 1)); // 28
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 1)); // 29
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 1)); // 30
    // fill, then reset with a full stalled pipe
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h61, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 0)); // 31
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h62, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 1)); // 32
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h63, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 2)); // 33
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h64, 1'b0, 1'b1, 1'b0, 1'b1, 32'h61, 3)); // 34
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  0)); // 35
    // fill, then reset and flush together
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h71, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  0)); // 36
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h72, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1)); // 37
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h73, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  2)); // 38
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h74, 1'b1, 1'b1, 1'b0, 1'b0, 32'h71, 3)); // 39
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  0)); // 40
    // first word after reset sees full latency
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h81, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  0)); // 41
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1)); // 42
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1)); // 43
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h81, 1)); // 44

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst3 = vecs[i].rst; flush3 = vecs[i].flush; iv3 = vecs[i].iv;
      din3 = vecs[i].din; or3 = vecs[i].ordy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("d3 row%0d in_ready", i),  {31'd0, ir3}, {31'd0, vecs[i].e_ir});
        check($sformatf("d3 row%0d out_valid", i), {31'd0, ov3}, {31'd0, vecs[i].e_ov});
        check($sformatf("d3 row%0d out_data", i),  dout3, vecs[i].e_od);
`ifdef PIPE_OCCUPANCY_EN
        check($sformatf("d3 row%0d occupancy", i), {30'd0, occ3}, 32'(vecs[i].e_occ));
`endif
      end
    end

    // DEPTH=1: rst1 has been held high for the whole table above.
    //      name      rst   flush iv    din       ordy  e_ir  e_ov  e_od      occ
    step1("d1 rst",  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  0);
    step1("d1 s1",   1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h0,  0);
    step1("d1 s2",   1'b0, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 1);
    step1("d1 s3",   1'b0, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA1, 1);
    step1("d1 s4",   1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hA2, 1);
    step1("d1 s5",   1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 1);
    step1("d1 s6",   1'b0, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'hA2, 0);
    step1("d1 s7",   1'b0, 1'b1, 1'b1, 32'hA4, 1'b1, 1'b0, 1'b0, 32'hA3, 1);
    step1("d1 s8",   1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'hA3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
